// File: rtl/rc4_xor_unit.sv
// RC4 keystream combiner: XORs ciphertext byte lanes with keystream bytes
// and issues byte- or word-wide plaintext pixel writes to image memory.
module rc4_xor_unit #(
   parameter int WORD_BYTES = 4,
   parameter int PIX_CNT_W  = 20,
   parameter int NUM_PIXELS = 307200,
   localparam int LW = $clog2(WORD_BYTES),
   localparam int DW = 8 * WORD_BYTES
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 start_i,
   input  logic                 word_mode_i,
   input  logic [DW-1:0]        cipher_i,
   input  logic                 cipher_valid_i,
   output logic                 cipher_ready_o,
   input  logic [7:0]           keystream_i,
   input  logic                 ks_valid_i,
   output logic                 ks_ready_o,
   output logic                 wr_en_o,
   input  logic                 wr_ready_i,
   output logic [DW-1:0]        wr_data_o,
   output logic [WORD_BYTES-1:0] wr_byte_en_o,
   output logic [LW-1:0]        wr_lane_o,
   output logic [PIX_CNT_W-1:0] pix_num_o,
   output logic                 done_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_XOR,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [PIX_CNT_W-1:0] LAST_PIX =
      PIX_CNT_W'(NUM_PIXELS);
   localparam logic [LW-1:0] LANE_MAX = LW'(WORD_BYTES - 1);
   localparam logic [WORD_BYTES-1:0] BE_MSB =
      {1'b1, {(WORD_BYTES-1){1'b0}}};

   state_t               state;
   logic                 word_mode;
   logic [DW-1:0]        cipher_q;
   logic [LW-1:0]        lane;
   logic [PIX_CNT_W-1:0] pix_cnt;

   logic [PIX_CNT_W-1:0]  pix_nxt;
   logic [WORD_BYTES-1:0] lane_oh;
   logic [DW-1:0]         lane_mask;
   logic [DW-1:0]         pt_lane;
   logic                  last_byte;

   assign cipher_ready_o = (state == S_LOAD);
   assign ks_ready_o     = (state == S_XOR);
   assign wr_en_o        = (state == S_WRITE);

   assign pix_nxt = pix_cnt + 1'b1;
   // lane 0 sits in the MSBs, so its enable is the top bit
   assign lane_oh = BE_MSB >> lane;

   always_comb begin
      lane_mask = '0;
      for (int i = 0; i < WORD_BYTES; i++) begin
         lane_mask[8*i +: 8] = {8{lane_oh[i]}};
      end
   end

   assign pt_lane =
      (cipher_q ^ {WORD_BYTES{keystream_i}}) & lane_mask;

   assign last_byte = !word_mode
                    || (lane == LANE_MAX)
                    || (pix_nxt == LAST_PIX);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state        <= S_IDLE;
         word_mode    <= 1'b0;
         cipher_q     <= '0;
         lane         <= '0;
         pix_cnt      <= '0;
         wr_data_o    <= '0;
         wr_byte_en_o <= '0;
         wr_lane_o    <= '0;
         pix_num_o    <= '0;
         done_o       <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  state     <= S_LOAD;
                  pix_cnt   <= '0;
                  lane      <= '0;
                  word_mode <= word_mode_i;
                  done_o    <= 1'b0;
               end
            end
            S_LOAD: begin
               if (cipher_valid_i) begin
                  cipher_q     <= cipher_i;
                  wr_data_o    <= '0;
                  wr_byte_en_o <= '0;
                  state        <= S_XOR;
               end
            end
            S_XOR: begin
               if (ks_valid_i) begin
                  pix_cnt   <= pix_nxt;
                  lane      <= lane + 1'b1;
                  wr_lane_o <= lane;
                  if (word_mode) begin
                     wr_data_o    <= wr_data_o | pt_lane;
                     wr_byte_en_o <= wr_byte_en_o | lane_oh;
                     if (lane == '0) begin
                        pix_num_o <= pix_cnt;
                     end
                  end else begin
                     wr_data_o    <= pt_lane;
                     wr_byte_en_o <= lane_oh;
                     pix_num_o    <= pix_cnt;
                  end
                  if (last_byte) begin
                     state <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               if (wr_ready_i) begin
                  if (pix_cnt == LAST_PIX) begin
                     state  <= S_DONE;
                     done_o <= 1'b1;
                  end else if (lane != '0) begin
                     state <= S_XOR;
                  end else begin
                     state <= S_LOAD;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
